// File: rtl/spike_pkg.sv
// Shared types and default sizing for the spike time decoder.
package spike_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWindow,
    StDrain
  } state_e;

  localparam int unsigned DefNLines = 16;
  localparam int unsigned DefTWidth = 6;
  localparam int unsigned DefTMax   = 63;

  // Width of the out_idx beat field for the default line count.
  localparam int unsigned DefIdxWidth = $clog2(DefNLines);

endpackage

// File: rtl/edge_capture.sv
// Per-line capture: latches the window counter on the first low sample of one spike line.
module edge_capture
  import spike_pkg::*;
#(
  parameter int unsigned T_WIDTH = DefTWidth
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               spike_i,
  input  logic [T_WIDTH-1:0] t_i,
  input  logic               clear_i,
  input  logic               en_i,
  output logic [T_WIDTH-1:0] time_o,
  output logic               seen_o
);

  logic [T_WIDTH-1:0] time_q;
  logic               seen_q;

  // First low sample while enabled wins; later transitions never re-arm the line.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      time_q <= '0;
      seen_q <= 1'b0;
    end else if (en_i && !spike_i && !seen_q) begin
      time_q <= t_i;
      seen_q <= 1'b1;
    end
  end

  assign time_o = time_q;
  assign seen_o = seen_q;

endmodule

// File: rtl/spike_time_decoder.sv
// Spike time decoder: captures 1->0 times of N_LINES lines over a window,
// then streams one beat per line over valid/ready.
// Optional ordering check enabled by defining SPIKE_DEC_ORDER_CHECK_EN.
module spike_time_decoder
  import spike_pkg::*;
#(
  parameter int unsigned N_LINES = DefNLines,
  parameter int unsigned T_WIDTH = DefTWidth,
  parameter int unsigned T_MAX   = DefTMax
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [N_LINES-1:0]         spikes_i,
  output logic                       busy_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(N_LINES)-1:0] out_idx_o,
  output logic [T_WIDTH-1:0]         out_time_o,
  output logic                       out_fired_o,
  output logic                       out_last_o,
  output logic                       order_err_o
);

  localparam int unsigned IdxWidth = $clog2(N_LINES);
  localparam logic [T_WIDTH-1:0]  TMaxW = T_WIDTH'(T_MAX);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(N_LINES - 1);

  state_e              state_q, state_d;
  logic [T_WIDTH-1:0]  t_q, t_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic                clear, cap_en;

  logic [T_WIDTH-1:0]  cap_time [N_LINES];
  logic [N_LINES-1:0]  seen;
  logic                all_seen_next;
  logic                beat_xfer;

  for (genvar i = 0; i < N_LINES; i++) begin : g_line
    edge_capture #(
      .T_WIDTH (T_WIDTH)
    ) u_cap (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .spike_i (spikes_i[i]),
      .t_i     (t_q),
      .clear_i (clear),
      .en_i    (cap_en),
      .time_o  (cap_time[i]),
      .seen_o  (seen[i])
    );
  end

  // Seen vector as it will be after this edge's captures.
  assign all_seen_next = &(seen | ~spikes_i);
  assign beat_xfer     = (state_q == StDrain) && out_ready_i;

  // State, window counter and drain index registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      t_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: window runs until every line fired or the counter hits T_MAX.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    idx_d   = idx_q;
    clear   = 1'b0;
    cap_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StWindow;
          t_d     = '0;
          idx_d   = '0;
          clear   = 1'b1;
        end
      end
      StWindow: begin
        cap_en = 1'b1;
        // Counter saturates at T_MAX rather than wrapping.
        if (t_q != TMaxW) t_d = t_q + T_WIDTH'(1);
        if (all_seen_next || (t_q == TMaxW)) begin
          state_d = StDrain;
          idx_d   = '0;
        end
      end
      StDrain: begin
        if (out_ready_i) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxWidth'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Drain mux: unfired lines report T_MAX; all beat fields are zero outside DRAIN.
  always_comb begin
    busy_o      = (state_q != StIdle);
    out_valid_o = (state_q == StDrain);
    out_idx_o   = '0;
    out_time_o  = '0;
    out_fired_o = 1'b0;
    out_last_o  = 1'b0;
    if (state_q == StDrain) begin
      out_idx_o   = idx_q;
      out_fired_o = seen[idx_q];
      out_time_o  = seen[idx_q] ? cap_time[idx_q] : TMaxW;
      out_last_o  = (idx_q == LastIdx);
    end
  end

`ifdef SPIKE_DEC_ORDER_CHECK_EN
  logic [T_WIDTH-1:0] prev_time_q;
  logic               have_prev_q;
  logic               err_q;

  // Sticky flag when a fired beat's time is below the previous fired beat's time.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || ((state_q == StIdle) && start_i)) begin
      prev_time_q <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (beat_xfer && out_fired_o) begin
      if (have_prev_q && (out_time_o < prev_time_q)) err_q <= 1'b1;
      prev_time_q <= out_time_o;
      have_prev_q <= 1'b1;
    end
  end

  assign order_err_o = err_q;
`else
  logic unused_beat_xfer;
  assign unused_beat_xfer = beat_xfer;
  assign order_err_o      = 1'b0;
`endif

endmodule
